// File: rtl/piso_frame_tx.sv
// Parallel-in, serial-out framed transmitter: start bit (0), DATA_W data
// bits LSB first, stop bit (1), each bit held CLKS_PER_BIT clocks.
module piso_frame_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_out,
  output logic              busy,
  output logic              done
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t              state_q, state_n;
  logic [BAUD_W-1:0]   baud_q, baud_n;
  logic [BIT_W-1:0]    bit_q, bit_n;
  logic [DATA_W-1:0]   shift_q, shift_n;
  logic                tx_out_n, busy_n, done_n, ready_n;
  logic                bit_end;

  assign bit_end = (baud_q == BAUD_LAST);

  // Next-state and next-output logic; outputs are computed one cycle ahead
  // so that every port is driven straight from a flop.
  always_comb begin
    state_n  = state_q;
    baud_n   = baud_q;
    bit_n    = bit_q;
    shift_n  = shift_q;
    tx_out_n = 1'b1;
    busy_n   = 1'b1;
    done_n   = 1'b0;
    ready_n  = 1'b0;
    case (state_q)
      IDLE: begin
        busy_n  = 1'b0;
        ready_n = 1'b1;
        baud_n  = '0;
        bit_n   = '0;
        if (tx_valid && tx_ready) begin
          shift_n  = tx_data;
          state_n  = START;
          tx_out_n = 1'b0;
          busy_n   = 1'b1;
          ready_n  = 1'b0;
        end
      end
      START: begin
        tx_out_n = 1'b0;
        if (bit_end) begin
          baud_n   = '0;
          state_n  = DATA;
          tx_out_n = shift_q[0];
        end else begin
          baud_n = baud_q + 1'b1;
        end
      end
      DATA: begin
        tx_out_n = shift_q[0];
        if (bit_end) begin
          baud_n = '0;
          if (bit_q == BIT_LAST) begin
            state_n  = STOP;
            tx_out_n = 1'b1;
          end else begin
            // Line bit for the next cycle comes from the post-shift LSB.
            shift_n  = shift_q >> 1;
            bit_n    = bit_q + 1'b1;
            tx_out_n = shift_n[0];
          end
        end else begin
          baud_n = baud_q + 1'b1;
        end
      end
      STOP: begin
        tx_out_n = 1'b1;
        if (bit_end) begin
          baud_n  = '0;
          state_n = IDLE;
          busy_n  = 1'b0;
          ready_n = 1'b1;
          done_n  = 1'b1;
        end else begin
          baud_n = baud_q + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_out   <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      tx_ready <= 1'b0;
    end else begin
      state_q  <= state_n;
      baud_q   <= baud_n;
      bit_q    <= bit_n;
      shift_q  <= shift_n;
      tx_out   <= tx_out_n;
      busy     <= busy_n;
      done     <= done_n;
      tx_ready <= ready_n;
    end
  end

endmodule

// File: tb/tb_piso_frame_tx.sv
// Self-checking bench for piso_frame_tx: default geometry (8 bits, 4 clocks
// per bit) plus a degenerate 1-bit / 1-clock instance.
module tb_piso_frame_tx;

  localparam int W = 8;
  localparam int C = 4;
  localparam int N = (W + 2) * C;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] tx_data = '0;
  logic         tx_valid = 1'b0;
  logic         tx_ready, tx_out, busy, done;

  logic [0:0]   tx_data1 = '0;
  logic         tx_valid1 = 1'b0;
  logic         tx_ready1, tx_out1, busy1, done1;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  piso_frame_tx #(.DATA_W(W), .CLKS_PER_BIT(C)) dut (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_out(tx_out), .busy(busy), .done(done)
  );

  piso_frame_tx #(.DATA_W(1), .CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .reset(reset), .tx_data(tx_data1), .tx_valid(tx_valid1),
    .tx_ready(tx_ready1), .tx_out(tx_out1), .busy(busy1), .done(done1)
  );

  // Reference: line bit at frame position idx (0=start, 1..W data LSB first, W+1=stop).
  function automatic logic line_bit(input logic [W-1:0] d, input int idx);
    if (idx == 0) return 1'b0;
    if (idx > W) return 1'b1;
    return d[idx-1];
  endfunction

  // Sends one word on the main DUT and checks the whole frame cycle by cycle.
  // Entered and left at #1 after an edge where tx_ready is expected high.
  task automatic frame(input logic [W-1:0] d, input bit noise, input bit chain,
                       input logic [W-1:0] nxt);
    logic exp;
    total++;
    if (tx_ready !== 1'b1) begin
      bad++;
      $display("FAIL ready_before_accept got=%b exp=1", tx_ready);
    end
    tx_data  = d;
    tx_valid = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < N; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      exp = line_bit(d, k / C);
      total++;
      if ({tx_out, busy, done, tx_ready} !== {exp, 3'b100}) begin
        bad++;
        $display("FAIL frame_cycle data=%h k=%0d got out/busy/done/ready=%b%b%b%b exp=%b100",
                 d, k, tx_out, busy, done, tx_ready, exp);
      end
      if (noise) begin
        tx_valid = 1'($urandom_range(0, 1));
        tx_data  = (k == 0) ? 8'hFF : 8'($urandom);
      end else if (chain) begin
        tx_data = nxt;
      end else if (k == 0) begin
        tx_valid = 1'b0;
      end
    end
    tx_valid = chain;
    if (chain) tx_data = nxt;
    @(posedge clk); #1;
    total++;
    if ({tx_out, busy, done, tx_ready} !== 4'b1011) begin
      bad++;
      $display("FAIL frame_end data=%h got out/busy/done/ready=%b%b%b%b exp=1011",
               d, tx_out, busy, done, tx_ready);
    end
  endtask

  // One idle edge after a frame: done must have dropped and line stays high.
  task automatic idle_check(input string tag);
    tx_valid = 1'b0;
    @(posedge clk); #1;
    total++;
    if ({tx_out, busy, done, tx_ready} !== 4'b1001) begin
      bad++;
      $display("FAIL %s got out/busy/done/ready=%b%b%b%b exp=1001",
               tag, tx_out, busy, done, tx_ready);
    end
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    tx_valid  = 1'b1;
    tx_data   = 8'($urandom);
    tx_valid1 = 1'b1;
    tx_data1  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      total++;
      if ({tx_out, busy, done, tx_ready, tx_out1, busy1, done1, tx_ready1} !== 8'b1000_1000) begin
        bad++;
        $display("FAIL reset_hold i=%0d got=%b%b%b%b_%b%b%b%b exp=1000_1000", i,
                 tx_out, busy, done, tx_ready, tx_out1, busy1, done1, tx_ready1);
      end
    end
    reset = 1'b1;
    @(posedge clk); #1;
    tx_valid  = 1'b0;
    tx_valid1 = 1'b0;
    total++;
    if ({tx_out, busy, done, tx_ready, tx_out1, busy1, done1, tx_ready1} !== 8'b1001_1001) begin
      bad++;
      $display("FAIL reset_release got=%b%b%b%b_%b%b%b%b exp=1001_1001",
               tx_out, busy, done, tx_ready, tx_out1, busy1, done1, tx_ready1);
    end
    idle_check("reset_no_accept");
  endtask

  task automatic test_single();
    frame(8'hA5, 1'b0, 1'b0, 8'h00);
    idle_check("single_idle");
  endtask

  task automatic test_back_to_back();
    frame(8'h3C, 1'b0, 1'b1, 8'hFF);
    frame(8'hFF, 1'b0, 1'b0, 8'h00);
    idle_check("b2b_idle");
  endtask

  task automatic test_busy_ignore();
    frame(8'h00, 1'b1, 1'b0, 8'h00);
    idle_check("busy_ignore_idle");
  endtask

  task automatic test_reset_midframe();
    logic exp;
    tx_data  = 8'h55;
    tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    for (int k = 0; k <= 17; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      exp = line_bit(8'h55, k / C);
      total++;
      if ({tx_out, busy} !== {exp, 1'b1}) begin
        bad++;
        $display("FAIL midframe_pre k=%0d got out/busy=%b%b exp=%b1", k, tx_out, busy, exp);
      end
    end
    reset    = 1'b0;
    tx_valid = 1'b1;
    tx_data  = 8'hC3;
    @(posedge clk); #1;
    total++;
    if ({tx_out, busy, done, tx_ready} !== 4'b1000) begin
      bad++;
      $display("FAIL midframe_reset got out/busy/done/ready=%b%b%b%b exp=1000",
               tx_out, busy, done, tx_ready);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    total++;
    if ({tx_out, busy, done, tx_ready} !== 4'b1001) begin
      bad++;
      $display("FAIL midframe_release got out/busy/done/ready=%b%b%b%b exp=1001",
               tx_out, busy, done, tx_ready);
    end
    idle_check("midframe_idle");
    frame(8'h81, 1'b0, 1'b0, 8'h00);
    idle_check("after_reset_idle");
  endtask

  task automatic test_random();
    logic [W-1:0] cur, nxt;
    bit noise, chain;
    cur = 8'($urandom);
    for (int i = 0; i < 8; i++) begin
      nxt   = 8'($urandom);
      noise = 1'($urandom_range(0, 1));
      chain = 1'($urandom_range(0, 1));
      frame(cur, noise, chain, nxt);
      if (!chain) idle_check("random_idle");
      cur = nxt;
    end
    tx_valid = 1'b0;
    idle_check("random_end");
  endtask

  task automatic test_degenerate();
    logic [0:0] d;
    logic [2:0] seq;
    for (int t = 0; t < 4; t++) begin
      d   = (t == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      seq = {1'b1, d, 1'b0};
      total++;
      if (tx_ready1 !== 1'b1) begin
        bad++;
        $display("FAIL deg_ready got=%b exp=1", tx_ready1);
      end
      tx_data1  = d;
      tx_valid1 = 1'b1;
      @(posedge clk); #1;
      tx_valid1 = 1'b0;
      for (int k = 0; k < 3; k++) begin
        if (k > 0) begin @(posedge clk); #1; end
        total++;
        if ({tx_out1, busy1, done1, tx_ready1} !== {seq[k], 3'b100}) begin
          bad++;
          $display("FAIL deg_cycle d=%b k=%0d got=%b%b%b%b exp=%b100",
                   d, k, tx_out1, busy1, done1, tx_ready1, seq[k]);
        end
      end
      @(posedge clk); #1;
      total++;
      if ({tx_out1, busy1, done1, tx_ready1} !== 4'b1011) begin
        bad++;
        $display("FAIL deg_end d=%b got=%b%b%b%b exp=1011", d, tx_out1, busy1, done1, tx_ready1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_busy_ignore();
    test_reset_midframe();
    test_random();
    test_degenerate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/piso_frame_tx.md
Name: piso_frame_tx

Overview:
Parallel-in, serial-out framed transmitter. It is the sending end of the team's DFF-chain serial capture path.
- Accepts a parallel word through a valid/ready handshake.
- Shifts the word out on a single line as a frame: one start bit (0), DATA_W data bits LSB first, one stop bit (1).
- Each bit is held for CLKS_PER_BIT clocks.
- Sits between register-level producers and the serial line feeding the synchronous-DFF receiver.

Parameters:
DATA_W, 8, payload width in bits (>=1)
CLKS_PER_BIT, 4, clock cycles each line bit is held (>=1; value 1 must work)

Ports:
clk  input  1  single clock; all state updates on rising edge
reset  input  1  synchronous, active-low reset; sampled on rising edge of clk, priority over all other inputs
tx_data  input  DATA_W  word to send; sampled only on an accept edge
tx_valid  input  1  producer has a word on tx_data
tx_ready  output  1  transmitter can accept a word this cycle
tx_out  output  1  serial line; idles high
busy  output  1  frame in progress (START, DATA or STOP state)
done  output  1  one-cycle pulse when a frame completes

Behaviour:
- All outputs are registered.
- Reset values (after any edge with reset=0): tx_out=1, busy=0, done=0, tx_ready=0, state IDLE, counters 0, shift register 0.
- tx_ready rises on the first edge with reset=1.
- States: IDLE, START, DATA, STOP.
- IDLE:
  - tx_ready=1, tx_out=1, busy=0.
  - Accept occurs when tx_valid=1 and tx_ready=1 at an edge: tx_data is latched into the shift register, and on the same edge the state goes to START, tx_ready=0 and busy=1.
- START: tx_out=0 for CLKS_PER_BIT cycles, then DATA.
- DATA:
  - tx_out = shift[0]; each bit is held CLKS_PER_BIT cycles, then the register shifts right.
  - Bit counter runs 0..DATA_W-1; after bit DATA_W-1 completes, go to STOP.
- STOP:
  - tx_out=1 for CLKS_PER_BIT cycles.
  - On the final edge: state goes to IDLE, busy=0, tx_ready=1, done=1.
- done is high for exactly the first IDLE cycle after a frame, and 0 otherwise.
- Timing:
  - Frame line time is (DATA_W+2)*CLKS_PER_BIT cycles, starting the cycle after the accept edge.
  - done and tx_ready both assert (DATA_W+2)*CLKS_PER_BIT edges after the accept edge.
- Back-to-back: if tx_valid stays high, the next accept happens in the done cycle, i.e. one IDLE cycle between the stop bit and the next start bit. No word is lost or duplicated.
- tx_data and tx_valid changes while busy=1 are ignored; the latched word is unaffected.
- Baud counter:
  - Width max(1,clog2(CLKS_PER_BIT)); counts 0..CLKS_PER_BIT-1, then wraps to 0 on each bit boundary.
  - With CLKS_PER_BIT=1, each bit lasts exactly one cycle.
- Bit counter width is max(1,clog2(DATA_W)); no overflow past DATA_W-1.
- Reset mid-frame:
  - At the next edge with reset=0: tx_out=1, state IDLE, frame discarded, done stays 0.
  - A word presented during reset is not accepted.
- No X propagation: tx_out is driven at all times after the first reset edge.

Test Plan:
- Reset then idle: hold reset=0 for 3 edges, then release -> tx_out=1, busy=0, done=0 throughout. tx_ready=0 while reset is low, then 1 from the first edge after release.
- Single frame (DATA_W=8, CLKS_PER_BIT=4): send tx_data=0xA5 -> tx_out sequence 0, 1,0,1,0,0,1,0,1, 1, each bit held 4 cycles. busy=1 for 40 cycles. done=1 for exactly 1 cycle, 40 edges after the accept edge.
- Back-to-back: hold tx_valid=1 with 0x3C, then 0xFF -> second start bit begins exactly 1 cycle after the first stop bit ends. Line decodes 0x3C then 0xFF. Exactly two done pulses.
- Input ignored while busy: change tx_data from 0x00 to 0xFF mid-frame of 0x00 -> all data bits are 0, and no extra accept occurs.
- Reset mid-frame: assert reset=0 during data bit 3 of 0x55 -> tx_out=1 next edge, busy=0, no done pulse. After release, sending 0x81 transmits correctly.
- Degenerate timing (CLKS_PER_BIT=1, DATA_W=1): send 1 -> tx_out 0,1,1 over 3 cycles. done asserts 3 edges after accept.
